// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator call controller.
// Contents:
//   db_state_e               debounce FSM state encoding
//   DEBOUNCE_CYCLES_DEFAULT  default stable-time in clock cycles
//   cnt_width()              width of the debounce down-counter
//   pending_next()           next value of a floor's pending-call flag
package elevator_pkg;

  typedef enum logic [1:0] {
    DB_LOW      = 2'd0,
    DB_CHK_HIGH = 2'd1,
    DB_HIGH     = 2'd2,
    DB_CHK_LOW  = 2'd3
  } db_state_e;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

  // The counter is loaded with at most DEBOUNCE_CYCLES-1, so $clog2 of the
  // cycle count is always wide enough; keep at least one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

  // A clear arriving on the same edge as a press normally wins, so the car
  // standing at the floor with the door open never leaves a stale call.
  function automatic logic pending_next(input logic flag, input logic press,
                                        input logic clr, input logic press_wins);
    if (press_wins) return press | (flag & ~clr);
    return ~clr & (press | flag);
  endfunction

endpackage

// File: rtl/elevator_call_ctrl_if.sv
// Button / elevator-FSM signal bundle for elevator_call_ctrl.
// Signals:
//   btn0_i, btn1_i      raw call buttons (asynchronous, may bounce)
//   open_i              door-open status from the elevator FSM
//   floor0_i, floor1_i  car position from the elevator FSM
//   call0_o, call1_o    registered pending calls towards the elevator FSM
//   lamp0_o, lamp1_o    call-acknowledge lamps (equal to the calls)
// Modports: slave = the call controller, master = buttons + elevator FSM.
interface elevator_call_ctrl_if;
  logic btn0_i;
  logic btn1_i;
  logic open_i;
  logic floor0_i;
  logic floor1_i;
  logic call0_o;
  logic call1_o;
  logic lamp0_o;
  logic lamp1_o;

  modport slave (
    input  btn0_i, btn1_i, open_i, floor0_i, floor1_i,
    output call0_o, call1_o, lamp0_o, lamp1_o
  );

  modport master (
    output btn0_i, btn1_i, open_i, floor0_i, floor1_i,
    input  call0_o, call1_o, lamp0_o, lamp1_o
  );
endinterface

// File: rtl/elevator_call_ctrl_sva.sv
// Property checker bound into every elevator_call_ctrl instance.
// Ports: clock/reset plus the internal press, clear and pending-flag nets
// of both floors.
module elevator_call_ctrl_sva #(
  parameter int ERRNO = 0
) (
  input logic clk_i,
  input logic rst_i,
  input logic press0,
  input logic press1,
  input logic clr0,
  input logic clr1,
  input logic call0,
  input logic call1
);

  // The checks describe the intended behaviour; fault-injected builds
  // (ERRNO != 0) are expected to trip them.
  if (ERRNO >= 0) begin : g_chk
    a_clr0_wins: assert property (@(posedge clk_i) disable iff (!rst_i) clr0 |=> !call0);
    a_clr1_wins: assert property (@(posedge clk_i) disable iff (!rst_i) clr1 |=> !call1);
    a_press0_set: assert property (@(posedge clk_i) disable iff (!rst_i) (press0 && !clr0) |=> call0);
    a_press1_set: assert property (@(posedge clk_i) disable iff (!rst_i) (press1 && !clr1) |=> call1);
    a_press0_pulse: assert property (@(posedge clk_i) disable iff (!rst_i) press0 |=> !press0);
    a_press1_pulse: assert property (@(posedge clk_i) disable iff (!rst_i) press1 |=> !press1);
  end

endmodule

bind elevator_call_ctrl elevator_call_ctrl_sva #(.ERRNO(ERRNO)) u_sva (
  .clk_i  (clk_i),
  .rst_i  (rst_i),
  .press0 (press0),
  .press1 (press1),
  .clr0   (clr0),
  .clr1   (clr1),
  .call0  (call0_q),
  .call1  (call1_q)
);

// File: rtl/elevator_debouncer.sv
// Synchroniser + debounce FSM for one call button.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-low reset
//   btn    raw button level
//   press  one-cycle pulse when the button is accepted as pressed
//
// state       | meaning
// ------------+-------------------------------------------------
// DB_LOW      | button released and stable
// DB_CHK_HIGH | saw high, counting down before accepting a press
// DB_HIGH     | button pressed and stable
// DB_CHK_LOW  | saw low, counting down before accepting release
module elevator_debouncer
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int ERRNO           = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn,
  output logic press
);

  localparam int CW     = cnt_width(DEBOUNCE_CYCLES);
  localparam int LOAD_I = (ERRNO == 2) ? DEBOUNCE_CYCLES - 2 : DEBOUNCE_CYCLES - 1;
  localparam logic [CW-1:0] LOAD = CW'(LOAD_I);

  logic          sync_meta;
  logic          sync;
  db_state_e     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      state     <= DB_LOW;
      cnt       <= '0;
      press     <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync      <= sync_meta;
      press     <= 1'b0;
      case (state)
        DB_LOW: begin
          if (sync) begin
            state <= DB_CHK_HIGH;
            cnt   <= LOAD;
          end
        end
        DB_CHK_HIGH: begin
          if (!sync) begin
            state <= DB_LOW;
          end else if (cnt == '0) begin
            state <= DB_HIGH;
            press <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DB_HIGH: begin
          if (!sync) begin
            state <= DB_CHK_LOW;
            cnt   <= LOAD;
          end
        end
        DB_CHK_LOW: begin
          // Bouncing back high returns to HIGH silently: no second press.
          if (sync) begin
            state <= DB_HIGH;
          end else if (cnt == '0) begin
            state <= DB_LOW;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= DB_LOW;
      endcase
    end
  end

endmodule

// File: rtl/elevator_call_ctrl.sv
// Two-floor elevator call controller: debounces both call buttons and keeps
// one pending-call flag per floor, cleared when the car opens its door there.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-low reset
//   bus    elevator_call_ctrl_if.slave (buttons, FSM feedback, calls, lamps)
module elevator_call_ctrl
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int ERRNO           = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  elevator_call_ctrl_if.slave   bus
);

  logic press0;
  logic press1;
  logic clr0;
  logic clr1;
  logic call0_q;
  logic call1_q;

  elevator_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ERRNO(ERRNO)) u_db0 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .btn   (bus.btn0_i),
    .press (press0)
  );

  elevator_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ERRNO(ERRNO)) u_db1 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .btn   (bus.btn1_i),
    .press (press1)
  );

  assign clr0 = bus.open_i & bus.floor0_i;
  assign clr1 = bus.open_i & bus.floor1_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      call0_q <= 1'b0;
      call1_q <= 1'b0;
    end else begin
      call0_q <= pending_next(call0_q, press0, clr0, ERRNO == 1);
      call1_q <= pending_next(call1_q, press1, clr1, ERRNO == 1);
    end
  end

  assign bus.call0_o = call0_q;
  assign bus.call1_o = call1_q;
  assign bus.lamp0_o = call0_q;
  assign bus.lamp1_o = call1_q;

endmodule

// File: tb/tb_elevator_call_ctrl.sv
// Scoreboard bench for elevator_call_ctrl at DEBOUNCE_CYCLES = 4.
// Expected call/lamp values are queued with the cycle they become due
// when stimulus is driven; a negedge monitor pops and compares them.
module tb_elevator_call_ctrl;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_fail;

  typedef struct {
    int    due;
    logic  e0;
    logic  e1;
    string tag;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  elevator_call_ctrl_if bus ();

  elevator_call_ctrl #(.DEBOUNCE_CYCLES(4), .ERRNO(0)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input int due, input logic e0, input logic e1, input string tag);
    exp_t e;
    e.due = due;
    e.e0  = e0;
    e.e1  = e1;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (q.size() > 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    #6;
    check_eq("queue_drained", q.size(), 0);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      cur = q.pop_front();
      check_eq({cur.tag, "_call0"}, bus.call0_o, cur.e0);
      check_eq({cur.tag, "_lamp0"}, bus.lamp0_o, cur.e0);
      check_eq({cur.tag, "_call1"}, bus.call1_o, cur.e1);
      check_eq({cur.tag, "_lamp1"}, bus.lamp1_o, cur.e1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, s, c, f, g, h, j, r;
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b1;
    bus.btn0_i = 1'b0;
    bus.btn1_i = 1'b0;
    bus.open_i = 1'b0;
    bus.floor0_i = 1'b0;
    bus.floor1_i = 1'b0;
    #1 rst_n = 1'b0;

    // reset state
    tick(1);
    check_eq("rst_call0", bus.call0_o, 0);
    check_eq("rst_call1", bus.call1_o, 0);
    check_eq("rst_lamp0", bus.lamp0_o, 0);
    check_eq("rst_lamp1", bus.lamp1_o, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // clean press on floor 0: call after 8 edges, not at 7
    e = cyc;
    bus.btn0_i = 1'b1;
    push_exp(e + 7, 1'b0, 1'b0, "a_pre");
    push_exp(e + 8, 1'b1, 1'b0, "a_call0");
    push_exp(e + 19, 1'b1, 1'b0, "a_hold");
    tick(20);
    bus.btn0_i = 1'b0;

    // floor-1 bounce: 3 high / 3 low never accepted
    s = cyc;
    for (int i = 1; i <= 28; i += 3) push_exp(s + i, 1'b1, 1'b0, "b_bounce");
    for (int i = 0; i < 5; i++) begin
      bus.btn1_i = 1'b1;
      tick(3);
      bus.btn1_i = 1'b0;
      tick(3);
    end
    tick(6);

    // floor-1 press while floor 0 pending: both held
    c = cyc;
    bus.btn1_i = 1'b1;
    push_exp(c + 7, 1'b1, 1'b0, "c_pre");
    push_exp(c + 8, 1'b1, 1'b1, "c_both");
    tick(10);
    bus.btn1_i = 1'b0;
    tick(8);

    // clear floor 0 only, then floor 1
    f = cyc;
    bus.open_i = 1'b1;
    bus.floor0_i = 1'b1;
    push_exp(f, 1'b1, 1'b1, "d_before");
    push_exp(f + 1, 1'b0, 1'b1, "d_clr0");
    push_exp(f + 3, 1'b0, 1'b1, "d_keep1");
    tick(1);
    bus.open_i = 1'b0;
    bus.floor0_i = 1'b0;
    tick(3);
    f = cyc;
    bus.open_i = 1'b1;
    bus.floor1_i = 1'b1;
    push_exp(f + 1, 1'b0, 1'b0, "d_clr1");
    tick(1);
    bus.open_i = 1'b0;
    bus.floor1_i = 1'b0;
    tick(2);

    // press pulse on floor 1 coincides with clear at floor 1: clear wins
    g = cyc;
    bus.btn1_i = 1'b1;
    push_exp(g + 7, 1'b0, 1'b0, "e_pre");
    tick(7);
    bus.open_i = 1'b1;
    bus.floor1_i = 1'b1;
    push_exp(g + 8, 1'b0, 1'b0, "e_coincide");
    tick(1);
    bus.open_i = 1'b0;
    bus.floor1_i = 1'b0;
    push_exp(g + 12, 1'b0, 1'b0, "e_held");
    tick(6);
    bus.btn1_i = 1'b0;
    tick(10);

    // held floor-0 button through a clear: no re-set until a new press
    h = cyc;
    bus.btn0_i = 1'b1;
    push_exp(h + 8, 1'b1, 1'b0, "f_set");
    tick(10);
    bus.open_i = 1'b1;
    bus.floor0_i = 1'b1;
    push_exp(h + 11, 1'b0, 1'b0, "f_clr");
    tick(1);
    bus.open_i = 1'b0;
    bus.floor0_i = 1'b0;
    push_exp(h + 20, 1'b0, 1'b0, "f_held");
    tick(14);
    bus.btn0_i = 1'b0;
    tick(10);
    h = cyc;
    bus.btn0_i = 1'b1;
    push_exp(h + 7, 1'b0, 1'b0, "f_pre2");
    push_exp(h + 8, 1'b1, 1'b0, "f_repress");
    tick(9);

    // async reset with both pending, floor-0 button still held
    j = cyc;
    bus.btn1_i = 1'b1;
    push_exp(j + 8, 1'b1, 1'b1, "g_both");
    tick(10);
    r = cyc;
    bus.btn1_i = 1'b0;
    push_exp(r + 1, 1'b0, 1'b0, "g_in_rst");
    push_exp(r + 8, 1'b0, 1'b0, "g_pre");
    push_exp(r + 9, 1'b1, 1'b0, "g_recall");
    #1 rst_n = 1'b0;
    #1;
    check_eq("g_async_call0", bus.call0_o, 0);
    check_eq("g_async_call1", bus.call1_o, 0);
    check_eq("g_async_lamp0", bus.lamp0_o, 0);
    check_eq("g_async_lamp1", bus.lamp1_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(10);
    bus.btn0_i = 1'b0;

    drain(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
